// File: rtl/bus_gate_arbiter.sv
// Round-robin owner sequencer for a shared tristate bus: registered one-hot gate
// enables, programmable all-off turnaround between owners and optional hold timeout.
module bus_gate_arbiter #(
   parameter int N           = 4,
   parameter int TURN_CYCLES = 1,
   parameter int MAX_HOLD    = 0
) (
   input  logic                 clk,
   input  logic                 rst_l,
   input  logic [N-1:0]         req_h,
   output logic [N-1:0]         gate_en_h,
   output logic [$clog2(N)-1:0] grant_id,
   output logic                 busy_h,
   output logic                 preempt_h
);

   localparam int IW = $clog2(N);
   localparam int HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
   localparam int TW = (TURN_CYCLES < 2) ? 1 : $clog2(TURN_CYCLES);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
   localparam logic [TW-1:0] TURN_LAST = TW'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN  = 2'd1,
      ST_TURN = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  gate_d;
   logic [IW-1:0] id_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [TW-1:0] turn_q, turn_d;
   logic          pre_d;

   logic [IW-1:0] win_id;
   logic [N-1:0]  win_oh;
   logic          win_ok;
   logic [IW-1:0] win_next;

   // First requester at or after the round-robin pointer, wrapping mod N.
   always_comb begin
      logic [IW:0] sum;
      logic [IW-1:0] cand;
      win_id = '0;
      win_ok = 1'b0;
      sum    = '0;
      cand   = '0;
      for (int i = 0; i < N; i++) begin
         sum = {1'b0, ptr_q} + (IW+1)'(i);
         if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
         cand = sum[IW-1:0];
         if (!win_ok && req_h[cand]) begin
            win_ok = 1'b1;
            win_id = cand;
         end
      end
   end

   always_comb begin
      win_oh         = '0;
      win_oh[win_id] = 1'b1;
      win_next       = (win_id == IW'(N - 1)) ? '0 : win_id + IW'(1);
   end

   // While owning, gate_en_h is exactly the owner's one-hot mask.
   logic [N-1:0] others;
   logic         owner_req;
   logic         timeout;

   always_comb begin
      others    = req_h & ~gate_en_h;
      owner_req = |(req_h & gate_en_h);
      timeout   = (MAX_HOLD != 0) && (hold_q == HOLD_MAX) && owner_req && (|others);
   end

   always_comb begin
      logic grant;
      state_d = state_q;
      gate_d  = gate_en_h;
      id_d    = grant_id;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      turn_d  = turn_q;
      pre_d   = 1'b0;
      grant   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (win_ok) grant = 1'b1;
         end
         ST_OWN: begin
            if (owner_req && !timeout) begin
               if ((MAX_HOLD != 0) && (hold_q != HOLD_MAX)) hold_d = hold_q + HW'(1);
            end else begin
               pre_d  = timeout;
               gate_d = '0;
               if (others == '0) begin
                  state_d = ST_IDLE;
               end else if (TURN_CYCLES == 0) begin
                  grant = 1'b1;
               end else begin
                  state_d = ST_TURN;
                  turn_d  = TURN_LAST;
               end
            end
         end
         ST_TURN: begin
            if (turn_q != '0) begin
               turn_d = turn_q - TW'(1);
            end else if (win_ok) begin
               grant = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            gate_d  = '0;
         end
      endcase

      if (grant) begin
         state_d = ST_OWN;
         gate_d  = win_oh;
         id_d    = win_id;
         ptr_d   = win_next;
         hold_d  = HW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q   <= ST_IDLE;
         gate_en_h <= '0;
         grant_id  <= '0;
         ptr_q     <= '0;
         hold_q    <= '0;
         turn_q    <= '0;
         preempt_h <= 1'b0;
      end else begin
         state_q   <= state_d;
         gate_en_h <= gate_d;
         grant_id  <= id_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         turn_q    <= turn_d;
         preempt_h <= pre_d;
      end
   end

   assign busy_h = |gate_en_h;

endmodule

// File: tb/tb_bus_gate_arbiter.sv
// Bench for bus_gate_arbiter: seven parameter sets run side by side, each with its own
// reference model, expected-output queue and monitor, plus bus-safety property checks.
module tb_bus_gate_arbiter;

   localparam int N           = 4;
   localparam int NCFG        = 7;
   localparam int RAND_CYCLES = 10000;

   logic clk = 1'b0;
   int   total    = 0;
   int   bad      = 0;
   int   done_cnt = 0;

   always #5 clk = ~clk;

   function automatic int pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (r[2'((p + k) % N)]) return (p + k) % N;
      end
      return -1;
   endfunction

   for (genvar g = 0; g < NCFG; g++) begin : cfg
      localparam int TC = (g == 2 || g == 4) ? 0 : (g == 3 || g == 6) ? 2 : 1;
      localparam int MH = (g == 1) ? 3 : (g >= 4) ? 4 : 0;

      logic           rst_l;
      logic [N-1:0]   req;
      logic [N-1:0]   gate;
      logic [1:0]     gid;
      logic           busy;
      logic           pre;
      logic [7:0]     exp_q[$];

      // Reference state: owner -1 means nobody drives; gap counts remaining dead cycles.
      int   m_owner, m_last, m_ptr, m_hold, m_gap;
      logic m_pre;

      bus_gate_arbiter #(.N(N), .TURN_CYCLES(TC), .MAX_HOLD(MH)) dut (
         .clk       (clk),
         .rst_l     (rst_l),
         .req_h     (req),
         .gate_en_h (gate),
         .grant_id  (gid),
         .busy_h    (busy),
         .preempt_h (pre)
      );

      task automatic model_reset();
         m_owner = -1;
         m_last  = 0;
         m_ptr   = 0;
         m_hold  = 0;
         m_gap   = 0;
         m_pre   = 1'b0;
      endtask

      task automatic model_grant(input int w);
         m_owner = w;
         m_last  = w;
         m_ptr   = (w + 1) % N;
         m_hold  = 1;
      endtask

      task automatic model_step(input logic [N-1:0] r);
         logic [N-1:0] oth;
         logic [7:0]   e;
         int           w;
         m_pre = 1'b0;
         if (m_owner >= 0) begin
            oth = r & ~(4'(1) << m_owner);
            if (r[2'(m_owner)] && !(MH != 0 && m_hold == MH && oth != 0)) begin
               if (m_hold < MH) m_hold++;
            end else begin
               m_pre   = r[2'(m_owner)];
               m_owner = -1;
               if (oth != 0) begin
                  if (TC == 0) model_grant(pick(r, m_ptr));
                  else m_gap = TC;
               end
            end
         end else if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0) begin
               w = pick(r, m_ptr);
               if (w >= 0) model_grant(w);
            end
         end else begin
            w = pick(r, m_ptr);
            if (w >= 0) model_grant(w);
         end
         e[7:4] = (m_owner >= 0) ? (4'(1) << m_owner) : 4'b0000;
         e[3:2] = 2'(m_last);
         e[1]   = (m_owner >= 0);
         e[0]   = m_pre;
         exp_q.push_back(e);
      endtask

      task automatic drive(input logic [N-1:0] r);
         @(negedge clk);
         req = r;
         model_step(r);
      endtask

      task automatic check_val(input string name, input int act, input int exp);
         total++;
         if (act != exp) begin
            bad++;
            $display("FAIL cfg%0d %s: got %0d expected %0d at %0t", g, name, act, exp, $time);
         end
      endtask

      initial begin : stim
         logic [N-1:0] r;
         rst_l = 1'b0;
         req   = '0;
         model_reset();
         repeat (2) @(negedge clk);
         rst_l = 1'b1;
         // Single requester one cycle after reset, then release.
         drive(4'b0100);
         drive(4'b0100);
         drive(4'b0000);
         drive(4'b0100);
         drive(4'b0100);
         // Asynchronous reset in the middle of an owned cycle.
         @(posedge clk);
         #2;
         rst_l = 1'b0;
         req   = '0;
         #1;
         check_val("rst_gate", int'(gate), 0);
         check_val("rst_busy", int'(busy), 0);
         check_val("rst_grant_id", int'(gid), 0);
         check_val("rst_preempt", int'(pre), 0);
         model_reset();
         repeat (2) @(negedge clk);
         rst_l = 1'b1;

         if (g == 0) begin
            // Everyone requests; each owner lets go for one cycle after two owned cycles.
            for (int c = 0; c < 20; c++) begin
               r = 4'b1111;
               if (m_owner >= 0 && m_hold == 2) r = r & ~(4'(1) << m_owner);
               drive(r);
            end
            drive(4'b0000);
         end else if (g == 1) begin
            drive(4'b0001);
            for (int c = 0; c < 12; c++) drive(4'b0101);
            drive(4'b0000);
         end else if (g == 2) begin
            drive(4'b0010);
            drive(4'b1010);
            drive(4'b1010);
            drive(4'b1000);
            drive(4'b1000);
            drive(4'b0000);
         end

         r = 4'($urandom_range(0, 15));
         for (int c = 0; c < RAND_CYCLES; c++) begin
            for (int i = 0; i < N; i++) begin
               if ($urandom_range(0, 7) == 0) r = r ^ (4'(1) << i);
            end
            drive(r);
         end
         @(negedge clk);
         done_cnt++;
      end

      initial begin : mon
         logic [7:0] e;
         logic [7:0] act;
         int         prev_own, zeros, w, bound, worst;
         int         wait_c[N];
         bound    = N * (MH + TC) + N + ((MH == 0) ? 1000000 : 0);
         prev_own = -1;
         zeros    = 0;
         for (int i = 0; i < N; i++) wait_c[i] = 0;
         forever begin
            @(posedge clk);
            #1;
            if (!rst_l) begin
               prev_own = -1;
               zeros    = 0;
               for (int i = 0; i < N; i++) wait_c[i] = 0;
            end else if (exp_q.size() != 0) begin
               e   = exp_q.pop_front();
               act = {gate, gid, busy, pre};
               total++;
               if (act !== e) begin
                  bad++;
                  $display("FAIL cfg%0d outputs at %0t: got gate=%b id=%0d busy=%b pre=%b expected gate=%b id=%0d busy=%b pre=%b",
                           g, $time, act[7:4], act[3:2], act[1], act[0], e[7:4], e[3:2], e[1], e[0]);
               end
               total++;
               if ($countones(gate) > 1) begin
                  bad++;
                  $display("FAIL cfg%0d onehot at %0t: got gate=%b expected at most one bit", g, $time, gate);
               end
               if (gate != 0) begin
                  w = 0;
                  for (int i = 0; i < N; i++) if (gate[i]) w = i;
                  if (prev_own >= 0 && w != prev_own) begin
                     total++;
                     if (zeros < ((TC > 0) ? 1 : 0)) begin
                        bad++;
                        $display("FAIL cfg%0d dead_gap at %0t: got %0d zero cycles between owners %0d and %0d, expected >= 1",
                                 g, $time, zeros, prev_own, w);
                     end
                  end
                  prev_own = w;
                  zeros    = 0;
               end else begin
                  zeros++;
               end
               worst = 0;
               for (int i = 0; i < N; i++) begin
                  if (req[i] && !gate[i]) wait_c[i]++;
                  else wait_c[i] = 0;
                  if (wait_c[i] > worst) worst = wait_c[i];
               end
               total++;
               if (worst > bound) begin
                  bad++;
                  $display("FAIL cfg%0d starvation at %0t: got wait %0d cycles, expected <= %0d", g, $time, worst, bound);
               end
            end
         end
      end
   end

   initial begin : top
      int cyc;
      cyc = 0;
      while (done_cnt < NCFG && cyc < 20000) begin
         @(posedge clk);
         cyc++;
      end
      total++;
      if (done_cnt < NCFG) begin
         bad++;
         $display("FAIL finish_timeout: got %0d configs done, expected %0d", done_cnt, NCFG);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
